// File: rtl/matdet_sched_pkg.sv
// Shared definitions for the determinant scheduler: FSM encoding, element
// placement inside a packed matrix, and id-width sizing.
package matdet_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  // Bit offset of element (r,c) inside one packed n x n matrix of w-bit elements.
  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

  // Index width that stays at least one bit when there is a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matdet_sched_if.sv
// Request/result bundle between requesters, result consumer and matdet_sched.
interface matdet_sched_if
  import matdet_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 3,
  parameter int NUM_REQ     = 4
);

  localparam int MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;
  localparam int ID_W  = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*MAT_W-1:0]   req_matrix;
  logic                       res_valid;
  logic                       res_ready;
  logic [DATA_WIDTH-1:0]      res_det;
  logic [ID_W-1:0]            res_id;
  logic                       busy;

  modport master (
    output req_valid, req_matrix, res_ready,
    input  req_ready, res_valid, res_det, res_id, busy
  );

  modport slave (
    input  req_valid, req_matrix, res_ready,
    output req_ready, res_valid, res_det, res_id, busy
  );

endinterface

// File: rtl/matdet_sched_matdet3.sv
// Combinational 3x3 determinant; arithmetic wraps at DATA_WIDTH, which equals
// the full-precision result truncated to DATA_WIDTH.
module matdet3
  import matdet_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [9*DATA_WIDTH-1:0] matrix,
  output logic [DATA_WIDTH-1:0]   det
);

  logic signed [DATA_WIDTH-1:0] m [9];
  logic signed [DATA_WIDTH-1:0] cof0;
  logic signed [DATA_WIDTH-1:0] cof1;
  logic signed [DATA_WIDTH-1:0] cof2;

  for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
    assign m[gi] = matrix[elem_lsb(gi / 3, gi % 3, 3, DATA_WIDTH) +: DATA_WIDTH];
  end

  assign cof0 = m[4] * m[8] - m[5] * m[7];
  assign cof1 = m[3] * m[8] - m[5] * m[6];
  assign cof2 = m[3] * m[7] - m[4] * m[6];
  assign det  = m[0] * cof0 - m[1] * cof1 + m[2] * cof2;

endmodule

// File: rtl/matdet_sched_rr_arbiter.sv
// Round-robin selector: one-hot grant starting after the last granted
// requester; the pointer only moves when the grant is actually taken.
module rr_arbiter
  import matdet_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = id_width(NUM_REQ);

  logic [PTR_W-1:0] last_reg;
  logic [PTR_W-1:0] last_next;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(last_reg) + i) % NUM_REQ]) begin
        grant[(int'(last_reg) + i) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    last_next = last_reg;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        last_next = PTR_W'(i);
      end
    end
  end

  // Reset points at the top requester so the first search begins at 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      last_reg <= PTR_W'(NUM_REQ - 1);
    end else if (advance) begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/matdet_sched.sv
// Shares one determinant datapath among NUM_REQ requesters: round-robin
// accept in IDLE, one cycle of compute, then hold the result until taken.
module matdet_sched
  import matdet_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 3,
  parameter int NUM_REQ     = 4
) (
  input  logic            clk,
  input  logic            rst,
  matdet_sched_if.slave   bus
);

  localparam int MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;
  localparam int ID_W  = id_width(NUM_REQ);

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [MAT_W-1:0]      operand_reg;
  logic [ID_W-1:0]       id_reg;
  logic [ID_W-1:0]       res_id_reg;
  logic [DATA_WIDTH-1:0] res_det_reg;
  logic                  res_valid_reg;
  logic [DATA_WIDTH-1:0] det_comb;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  idle;
  logic                  accept;
  logic [MAT_W-1:0]      slice [NUM_REQ];

  assign idle   = (state_reg == ST_IDLE);
  assign accept = idle && !rst && (|bus.req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .srst    (rst),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Grants are only visible while idle and out of reset.
  assign bus.req_ready = (idle && !rst) ? grant : '0;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = ID_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = bus.req_matrix[gi*MAT_W +: MAT_W];
  end

  // Datapath for the configured size; sizes above 3 have no datapath here.
  if (MATRIX_SIZE == 3) begin : g_det3
    matdet3 #(.DATA_WIDTH(DATA_WIDTH)) u_det (
      .matrix (operand_reg),
      .det    (det_comb)
    );
  end else if (MATRIX_SIZE == 2) begin : g_det2
    assign det_comb =
        operand_reg[elem_lsb(0, 0, 2, DATA_WIDTH) +: DATA_WIDTH] *
        operand_reg[elem_lsb(1, 1, 2, DATA_WIDTH) +: DATA_WIDTH] -
        operand_reg[elem_lsb(0, 1, 2, DATA_WIDTH) +: DATA_WIDTH] *
        operand_reg[elem_lsb(1, 0, 2, DATA_WIDTH) +: DATA_WIDTH];
  end else if (MATRIX_SIZE == 1) begin : g_det1
    assign det_comb = operand_reg[DATA_WIDTH-1:0];
  end else begin : g_det_none
    assign det_comb = '0;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (accept) state_next = ST_COMPUTE;
      ST_COMPUTE: state_next = ST_HOLD;
      ST_HOLD:    if (bus.res_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      operand_reg   <= '0;
      id_reg        <= '0;
      res_id_reg    <= '0;
      res_det_reg   <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        operand_reg <= slice[grant_idx];
        id_reg      <= grant_idx;
      end
      if (state_reg == ST_COMPUTE) begin
        res_det_reg   <= det_comb;
        res_id_reg    <= id_reg;
        res_valid_reg <= 1'b1;
      end else if (state_reg == ST_HOLD && bus.res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.res_valid = res_valid_reg;
  assign bus.res_det   = res_det_reg;
  assign bus.res_id    = res_id_reg;
  assign bus.busy      = !idle;

endmodule

// File: tb/tb_matdet_sched.sv
// Bench for matdet_sched: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_matdet_sched;
  import matdet_sched_pkg::*;

  localparam int DW    = 16;
  localparam int MS    = 3;
  localparam int NR    = 4;
  localparam int MAT_W = MS * MS * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matdet_sched_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .NUM_REQ(NR)) bus ();

  matdet_sched #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_elem(input int k, input int r, input int c, input int v);
    bus.req_matrix[k*MAT_W + elem_lsb(r, c, MS, DW) +: DW] = DW'(v);
  endtask

  function automatic int get_elem(input int k, input int r, input int c);
    logic signed [DW-1:0] e;
    e = bus.req_matrix[k*MAT_W + elem_lsb(r, c, MS, DW) +: DW];
    return int'(e);
  endfunction

  task automatic set_rows(input int k, input int a0, input int a1, input int a2,
                          input int b0, input int b1, input int b2,
                          input int c0, input int c1, input int c2);
    set_elem(k, 0, 0, a0); set_elem(k, 0, 1, a1); set_elem(k, 0, 2, a2);
    set_elem(k, 1, 0, b0); set_elem(k, 1, 1, b1); set_elem(k, 1, 2, b2);
    set_elem(k, 2, 0, c0); set_elem(k, 2, 1, c1); set_elem(k, 2, 2, c2);
  endtask

  task automatic rand_mat(input int k);
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        set_elem(k, r, c, int'($urandom_range(0, 18)) - 9);
  endtask

  // Leibniz expansion over all permutations of the column indices.
  function automatic int ref_det(input int k);
    int s;
    int inv;
    int term;
    s = 0;
    for (int p0 = 0; p0 < 3; p0++)
      for (int p1 = 0; p1 < 3; p1++)
        for (int p2 = 0; p2 < 3; p2++)
          if (p0 != p1 && p0 != p2 && p1 != p2) begin
            inv  = int'(p0 > p1) + int'(p0 > p2) + int'(p1 > p2);
            term = get_elem(k, 0, p0) * get_elem(k, 1, p1) * get_elem(k, 2, p2);
            s    = (inv % 2 == 1) ? s - term : s + term;
          end
    return s;
  endfunction

  // Model: at most one outstanding job; result visible two cycles after accept.
  bit m_out  = 1'b0;
  int m_acc  = 0;
  int m_det  = 0;
  int m_id   = 0;
  int m_last = NR - 1;

  int g_idx[$];
  int g_cyc[$];
  int r_det[$];
  int r_id[$];
  int r_cyc[$];

  always @(negedge clk) begin
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] exp_det;
    bit            exp_rv;
    int            pick;
    int            j;
    if (armed) begin
      exp_ready = '0;
      pick      = -1;
      if (!rst && !m_out) begin
        for (int i = 1; i <= NR; i++) begin
          j = (m_last + i) % NR;
          if (pick < 0 && bus.req_valid[j]) pick = j;
        end
      end
      if (pick >= 0) exp_ready[pick] = 1'b1;
      exp_rv  = m_out && (cyc >= m_acc + 2);
      exp_det = m_det[DW-1:0];

      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("busy", 64'(bus.busy), 64'(m_out));
      chk("res_valid", 64'(bus.res_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("res_det", 64'(bus.res_det), 64'(exp_det));
        chk("res_id", 64'(bus.res_id), 64'(m_id));
      end

      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i] === 1'b1) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc);
          $display("[TB] cycle %0d grant requester %0d", cyc, i);
        end
      end
      if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        r_det.push_back(int'(bus.res_det));
        r_id.push_back(int'(bus.res_id));
        r_cyc.push_back(cyc);
        $display("[TB] cycle %0d result id %0d det %04h", cyc, bus.res_id, bus.res_det);
      end

      if (rst) begin
        m_out  = 1'b0;
        m_last = NR - 1;
      end else if (pick >= 0) begin
        m_out  = 1'b1;
        m_acc  = cyc;
        m_det  = ref_det(pick);
        m_id   = pick;
        m_last = pick;
      end else if (exp_rv && bus.res_ready) begin
        m_out = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int idx);
    int  n0;
    bit  ok;
    n0 = g_idx.size();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (g_idx.size() > n0) ok = 1'b1;
    end
    if (!ok) chk("grant_timeout", 64'd0, 64'd1);
    idx = ok ? g_idx[$] : -1;
  endtask

  task automatic wait_res(input bit rnd);
    int n0;
    bit ok;
    n0 = r_det.size();
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (rnd) bus.res_ready = 1'($urandom_range(0, 1));
      tick();
      if (r_det.size() > n0) ok = 1'b1;
    end
    bus.res_ready = 1'b1;
    if (!ok) chk("result_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.res_ready  = 1'b1;
    bus.req_matrix = '0;
    tick();
    armed = 1'b1;
    bus.req_valid = 4'hF;
    tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_det", 64'(bus.res_det), 64'd0);
    chk("rst_res_id", 64'(bus.res_id), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // Requester 2 alone, diag(2,3,4).
    set_rows(2, 2, 0, 0, 0, 3, 0, 0, 0, 4);
    bus.req_valid = 4'b0100;
    wait_grant(g);
    bus.req_valid = '0;
    wait_res(1'b0);
    chk("diag_grant", 64'(g), 64'd2);
    chk("diag_det", 64'(r_det[$]), 64'h0018);
    chk("diag_id", 64'(r_id[$]), 64'd2);
    chk("diag_latency", 64'(r_cyc[$] - g_cyc[$]), 64'd2);

    // Permutation matrix: determinant -1.
    set_rows(0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    bus.req_valid = 4'b0001;
    wait_grant(g);
    bus.req_valid = '0;
    wait_res(1'b0);
    chk("perm_det", 64'(r_det[$]), 64'hFFFF);
    chk("perm_id", 64'(r_id[$]), 64'd0);

    // All requesters held from reset: order 0,1,2,3,0 at a 3-cycle pitch.
    for (int k = 0; k < NR; k++) rand_mat(k);
    rst = 1'b1;
    bus.req_valid = 4'hF;
    tick();
    rst = 1'b0;
    n0 = g_idx.size();
    for (int i = 0; i < 40 && g_idx.size() < n0 + 5; i++) tick();
    bus.req_valid = '0;
    chk("rr_grant_count", 64'(g_idx.size() - n0), 64'd5);
    if (g_idx.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", 64'(g_idx[n0 + i]), 64'(exp_order[i]));
        if (i > 0) chk("rr_spacing", 64'(g_cyc[n0 + i] - g_cyc[n0 + i - 1]), 64'd3);
      end
    end
    for (int i = 0; i < 10 && bus.busy; i++) tick();

    // Consumer stalls for 5 cycles while another requester waits.
    bus.res_ready = 1'b0;
    set_rows(1, 2, 0, 0, 0, 3, 0, 0, 0, 4);
    set_rows(3, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    bus.req_valid = 4'b0010;
    wait_grant(g);
    bus.req_valid = 4'b1000;
    for (int i = 0; i < 10 && !bus.res_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_det", 64'(bus.res_det), 64'h0018);
      chk("hold_id", 64'(bus.res_id), 64'd1);
      chk("hold_no_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    chk("release_busy", 64'(bus.busy), 64'd0);
    chk("release_grant", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = '0;
    wait_res(1'b0);
    chk("release_next_det", 64'(r_det[$]), 64'h0001);
    chk("release_next_id", 64'(r_id[$]), 64'd3);

    // Reset while computing discards the job and restores priority to 0.
    for (int k = 0; k < NR; k++) rand_mat(k);
    bus.req_valid = 4'b0100;
    wait_grant(g);
    n0 = r_det.size();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 64'(bus.res_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    bus.req_valid = 4'hF;
    #1;
    chk("midrst_grant", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    wait_res(1'b0);
    chk("midrst_results", 64'(r_det.size() - n0), 64'd1);
    chk("midrst_id", 64'(r_id[$]), 64'd0);

    // Random matrices from random requester subsets, stalling consumer.
    n0 = r_det.size();
    for (int t = 0; t < 1000; t++) begin
      bus.req_valid = '0;
      for (int k = 0; k < NR; k++) rand_mat(k);
      bus.req_valid = NR'($urandom_range(1, 15));
      wait_grant(g);
      bus.req_valid = '0;
      for (int k = 0; k < NR; k++) rand_mat(k);
      wait_res(1'b1);
      chk("rand_id", 64'(r_id[$]), 64'(g));
    end
    chk("rand_count", 64'(r_det.size() - n0), 64'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
